sine_freq_meter: RTL and testbench

// Receive-side counterpart of the DDS generator. It measures the frequency of an 8-bit offset-binary

---
 rtl/sine_freq_meter.sv | 173 +++++++++++++++++
 tb/tb_sine_freq_meter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_freq_meter.sv
// sine_freq_meter: estimates the DDS tuning word of an 8-bit offset-binary sinusoid.
// Rising midscale crossings (with hysteresis) are counted over a gate window of
// 2**GATE_LOG2 clocks; a 32-step restoring divider then converts N periods spanning
// Tlast clocks into ftw = floor(N * 2**32 / Tlast).
module sine_freq_meter #(
   parameter int GATE_LOG2 = 16,
   parameter int HYST      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_valid,
   input  logic [7:0]           adc_data,
   input  logic                 start,
   output logic                 busy,
   output logic                 result_valid,
   output logic [31:0]          ftw_est,
   output logic [GATE_LOG2:0]   period_count,
   output logic                 no_signal
);

   localparam logic [7:0]           HI_THR = 8'(128 + HYST);
   localparam logic [7:0]           LO_THR = 8'(128 - HYST);
   localparam logic [GATE_LOG2-1:0] W_LAST = '1;
   localparam logic [GATE_LOG2:0]   N_MAX  = {1'b1, {GATE_LOG2{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_MEASURE,
      S_DIVIDE,
      S_DONE
   } state_t;

   state_t               state;
   logic                 hi;
   logic                 rise;
   logic [GATE_LOG2-1:0] w_cnt;     // gate window position
   logic [GATE_LOG2-1:0] t_cnt;     // clocks since the first rise, minus one
   logic [GATE_LOG2-1:0] t_last;    // clocks from first rise to latest counted rise
   logic [GATE_LOG2:0]   n_cnt;     // whole periods seen after the first rise
   logic [GATE_LOG2:0]   n_inc;
   logic [GATE_LOG2:0]   n_fin;     // N including a rise in the current cycle
   logic [GATE_LOG2+1:0] rem;       // divider partial remainder, always < Tlast
   logic [GATE_LOG2+1:0] rem_shift;
   logic [GATE_LOG2+1:0] rem_sub;
   logic [GATE_LOG2+1:0] t_ext;
   logic                 q_bit;
   logic                 sat;
   logic [31:0]          quo;
   logic [4:0]           div_step;

   // Hysteresis flag: set above the upper threshold, cleared below the lower one, held in the band
   // NOTE: sequential state is written with <= so every flop samples pre-edge values together.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi <= 1'b0;
      end else if (sample_valid) begin
         if (adc_data >= HI_THR) begin
            hi <= 1'b1;
         end else if (adc_data <= LO_THR) begin
            hi <= 1'b0;
         end
      end
   end

   // Rise strobe, saturating period increment and one restoring-divider trial subtraction
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      rise      = 1'b0;
      n_inc     = n_cnt;
      n_fin     = n_cnt;
      t_ext     = {2'b00, t_last};
      rem_shift = {rem[GATE_LOG2:0], 1'b0};
      rem_sub   = '0;
      q_bit     = 1'b0;
      sat       = 1'b0;

      rise = sample_valid && !hi && (adc_data >= HI_THR);
      if (n_cnt != N_MAX) begin
         n_inc = n_cnt + 1'b1;
      end
      if (rise) begin
         n_fin = n_inc;
      end
      q_bit   = (rem_shift >= t_ext);
      rem_sub = rem_shift - t_ext;
      // A quotient of 2**32 or more cannot be represented; clamp it.
      sat     = ({1'b0, t_last} <= n_cnt);
   end

   // Measurement sequencer: arm on first rise, gate, divide, publish registered results
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         w_cnt        <= '0;
         t_cnt        <= '0;
         t_last       <= '0;
         n_cnt        <= '0;
         rem          <= '0;
         quo          <= '0;
         div_step     <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         ftw_est      <= '0;
         period_count <= '0;
         no_signal    <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state  <= S_ARM;
                  busy   <= 1'b1;
                  w_cnt  <= '0;
                  t_cnt  <= '0;
                  t_last <= '0;
                  n_cnt  <= '0;
               end
            end
            S_ARM: begin
               w_cnt <= w_cnt + 1'b1;
               // The window end wins over a late first rise, keeping the gate length fixed.
               if (w_cnt == W_LAST) begin
                  state <= S_DONE;
               end else if (rise) begin
                  state <= S_MEASURE;
                  t_cnt <= '0;
               end
            end
            S_MEASURE: begin
               w_cnt <= w_cnt + 1'b1;
               t_cnt <= t_cnt + 1'b1;
               if (rise) begin
                  n_cnt  <= n_inc;
                  t_last <= t_cnt + 1'b1;
               end
               if (w_cnt == W_LAST) begin
                  rem      <= {1'b0, n_fin};
                  quo      <= '0;
                  div_step <= '0;
                  state    <= (n_fin != '0) ? S_DIVIDE : S_DONE;
               end
            end
            S_DIVIDE: begin
               rem      <= q_bit ? rem_sub : rem_shift;
               quo      <= {quo[30:0], q_bit};
               div_step <= div_step + 1'b1;
               if (div_step == 5'd31) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               result_valid <= 1'b1;
               busy         <= 1'b0;
               period_count <= n_cnt;
               no_signal    <= (n_cnt == '0);
               if (n_cnt == '0) begin
                  ftw_est <= '0;
               end else if (sat) begin
                  ftw_est <= '1;
               end else begin
                  ftw_est <= quo;
               end
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sine_freq_meter.sv
// tb_sine_freq_meter: scoreboard bench. The driver generates sample streams, predicts each
// measurement from the list of qualified rising crossings inside the gate window, and queues
// the expectation; an independent monitor checks every result_valid pulse against the queue.
module tb_sine_freq_meter;

   localparam int G    = 11;
   localparam int HYST = 4;
   localparam int WIN  = 1 << G;

   localparam int K_DDS     = 0;
   localparam int K_PATTERN = 1;
   localparam int K_CONST   = 2;
   localparam int K_NOISE   = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         sample_valid = 1'b0;
   logic [7:0]   adc_data = 8'd128;
   logic         start = 1'b0;
   logic         busy;
   logic         result_valid;
   logic [31:0]  ftw_est;
   logic [G:0]   period_count;
   logic         no_signal;

   sine_freq_meter #(.GATE_LOG2(G), .HYST(HYST)) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .adc_data     (adc_data),
      .start        (start),
      .busy         (busy),
      .result_valid (result_valid),
      .ftw_est      (ftw_est),
      .period_count (period_count),
      .no_signal    (no_signal)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [31:0] ftw;
      int          n;
      bit          nosig;
      int          due;
      bit          spec_chk;
      logic [31:0] spec_ftw;
      int          tol;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_tol(input string name, input logic [31:0] act, input logic [31:0] exp,
                            input int tol);
      longint diff;
      n_cmp++;
      diff = longint'(act) - longint'(exp);
      if (diff < 0) diff = -diff;
      if ($isunknown(act) || diff > tol) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h +/-%0d", name, act, exp, tol);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (result_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("spurious_result_valid", 64'(result_valid), 64'(0));
            end else begin
               e = sb.pop_front();
               check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
               check({e.name, "_ftw"}, 64'(ftw_est), 64'(e.ftw));
               check({e.name, "_period_count"}, 64'(period_count), 64'(e.n));
               check({e.name, "_no_signal"}, 64'(no_signal), 64'(e.nosig));
               check({e.name, "_busy_low"}, 64'(busy), 64'(0));
               if (e.spec_chk) check_tol({e.name, "_spec_ftw"}, ftw_est, e.spec_ftw, e.tol);
            end
         end else if (sb.size() > 0 && cyc > sb[0].due) begin
            e = sb.pop_front();
            check({e.name, "_missing_result"}, 64'(0), 64'(1));
         end
      end
   end

   // ---------------- stimulus sources ----------------
   int          kind = K_CONST;
   logic [31:0] acc = '0;
   logic [31:0] ftw_s = '0;
   int          amp = 120;
   int          vpct = 100;
   int          tick = 0;
   bit          hi_m = 1'b0;

   task automatic gen(output bit v, output logic [7:0] d);
      real ph;
      int  val;
      val = 128;
      case (kind)
         K_DDS: begin
            ph  = 2.0 * 3.14159265358979 * real'(acc) / 4294967296.0;
            val = 128 + $rtoi($floor(real'(amp) * $sin(ph) + 0.5));
            acc = acc + ftw_s;
         end
         K_PATTERN: begin
            case (tick % 4)
               0: val = 128;
               1: val = 255;
               2: val = 128;
               default: val = 1;
            endcase
         end
         K_NOISE: val = 128 + int'($urandom_range(0, 6)) - 3;
         default: val = 128;
      endcase
      if (val < 0) val = 0;
      if (val > 255) val = 255;
      d = 8'(val);
      if (vpct == 50) v = tick[0];
      else v = (int'($urandom_range(0, 99)) < vpct);
      tick++;
   endtask

   // Drive one cycle at the falling edge; return whether this sample is a qualified rise.
   task automatic step(input bit s, input bit v, input logic [7:0] d, input bit r, output bit rz);
      @(negedge clk);
      start        = s;
      sample_valid = v;
      adc_data     = d;
      reset        = r;
      rz = 1'b0;
      if (r) begin
         hi_m = 1'b0;
      end else if (v) begin
         if (int'(d) >= 128 + HYST) begin
            rz   = !hi_m;
            hi_m = 1'b1;
         end else if (int'(d) <= 128 - HYST) begin
            hi_m = 1'b0;
         end
      end
   endtask

   // One measurement: start, full gate window, then enough idle cycles for divide and publish.
   task automatic measure(input string name, input bit spec_chk, input logic [31:0] spec_ftw,
                          input int tol, input int xs_k, input int xs_j, input int rst_j,
                          input bit push);
      bit          v, rz;
      logic [7:0]  d;
      int          e0, first, last, cnt, tl;
      exp_t        e;
      gen(v, d);
      step(1'b1, v, d, 1'b0, rz);
      check({name, "_idle_before_start"}, 64'(busy), 64'(0));
      e0 = cyc + 1;
      first = -1;
      last  = -1;
      cnt   = 0;
      for (int k = 1; k <= WIN; k++) begin
         gen(v, d);
         step(k == xs_k, v, d, 1'b0, rz);
         if (k == 1) check({name, "_busy_after_start"}, 64'(busy), 64'(1));
         if (rz) begin
            if (first < 0) first = k;
            last = k;
            cnt++;
         end
      end
      e.name     = name;
      e.n        = (cnt > 0) ? cnt - 1 : 0;
      e.nosig    = (e.n == 0);
      e.spec_chk = spec_chk;
      e.spec_ftw = spec_ftw;
      e.tol      = tol;
      if (e.n == 0) begin
         e.ftw = '0;
         e.due = e0 + WIN + 1;
      end else begin
         tl = last - first;
         if (e.n >= tl) e.ftw = 32'hFFFF_FFFF;
         else e.ftw = 32'((longint'(e.n) << 32) / longint'(tl));
         e.due = e0 + WIN + 33;
      end
      if (push) sb.push_back(e);
      for (int j = 1; j <= 34; j++) begin
         gen(v, d);
         step(j == xs_j, v, d, j == rst_j, rz);
         if (j == rst_j + 1) begin
            check({name, "_abort_busy"}, 64'(busy), 64'(0));
            check({name, "_abort_ftw"}, 64'(ftw_est), 64'(0));
            check({name, "_abort_valid"}, 64'(result_valid), 64'(0));
            check({name, "_abort_count"}, 64'(period_count), 64'(0));
         end
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin : driver
      bit rz;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd128, 1'b1, rz);
      step(1'b0, 1'b0, 8'd128, 1'b0, rz);
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_result_valid", 64'(result_valid), 64'(0));
      check("reset_ftw", 64'(ftw_est), 64'(0));
      check("reset_period_count", 64'(period_count), 64'(0));
      check("reset_no_signal", 64'(no_signal), 64'(0));

      // Period-256 DDS sine
      kind = K_DDS; ftw_s = 32'h0100_0000; amp = 120; vpct = 100; acc = $urandom;
      measure("dds256", 1'b1, 32'h0100_0000, 1, -1, -1, -1, 1'b1);

      // 128,255,128,1 repeating
      kind = K_PATTERN; tick = 0;
      measure("pattern4", 1'b1, 32'h4000_0000, 0, -1, -1, -1, 1'b1);

      // No signal: flat midscale, then in-band noise
      kind = K_CONST;
      measure("flat", 1'b1, 32'h0, 0, -1, -1, -1, 1'b1);
      kind = K_NOISE;
      measure("noise", 1'b1, 32'h0, 0, -1, -1, -1, 1'b1);

      // Extra starts mid-MEASURE and in the DONE cycle must be ignored
      kind = K_PATTERN; tick = 0;
      measure("restart_ignored", 1'b1, 32'h4000_0000, 0, WIN / 2, 33, -1, 1'b1);

      // Reset during DIVIDE aborts; the following run is clean
      kind = K_DDS; ftw_s = 32'h0100_0000; acc = $urandom;
      measure("aborted", 1'b0, 32'h0, 0, -1, -1, 10, 1'b0);
      measure("after_abort", 1'b1, 32'h0100_0000, 1, -1, -1, -1, 1'b1);

      // Period-512 signal sampled on every other clock
      kind = K_DDS; ftw_s = 32'h0080_0000; amp = 110; vpct = 50; acc = $urandom;
      measure("half_valid512", 1'b1, 32'h0080_0000, 1, -1, -1, -1, 1'b1);

      // Randomized tones, amplitudes and sample_valid density
      for (int r = 0; r < 10; r++) begin
         kind  = K_DDS;
         ftw_s = $urandom_range(32'hFFFF_FFFF / 6, 32'hFFFF_FFFF / 400);
         amp   = (r == 7) ? 3 : int'($urandom_range(20, 127));
         vpct  = int'($urandom_range(60, 100));
         acc   = $urandom;
         measure($sformatf("random%0d", r), 1'b0, 32'h0, 0, -1, -1, -1, 1'b1);
      end

      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'd128, 1'b0, rz);
      check("all_results_seen", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
